// File: rtl/writer_job_sched.sv
// rtl/writer_job_sched.sv - round-robin job scheduler sharing one AXI write master
// Optional job/error statistics counters: define WRITER_JOB_SCHED_STATS_EN.
module writer_job_sched #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int LEN_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len,
  output logic [ADDR_WIDTH-1:0]           wr_base_addr,
  output logic [LEN_WIDTH-1:0]            wr_burst_len,
  output logic                            wr_init_txn,
  input  logic                            wr_txn_done,
  input  logic                            wr_error,
  output logic                            cpl_valid,
  output logic [$clog2(NUM_REQ)-1:0]      cpl_id,
  output logic                            cpl_error,
  output logic                            cpl_timeout,
  output logic                            busy
`ifdef WRITER_JOB_SCHED_STATS_EN
  ,
  output logic [15:0]                     stat_jobs,
  output logic [15:0]                     stat_errs
`endif
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_REPORT} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   rr_ptr, job_id, winner;
  logic              found, accept;
  logic [CNT_W-1:0]  to_cnt;
  logic              done_q, done_edge, timeout_hit;
  logic              err_q, tmo_q;
  logic [LEN_WIDTH-1:0] winner_len;

  // Search from rr_ptr upward with wrap; first valid requester wins.
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && found && ARESETN)
      req_ready[winner] = 1'b1;
  end

  assign accept      = |req_ready;
  assign winner_len  = req_len[int'(winner)*LEN_WIDTH +: LEN_WIDTH];
  assign done_edge   = wr_txn_done & ~done_q;
  assign timeout_hit = (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = (winner_len == '0) ? S_REPORT : S_LAUNCH;
      S_LAUNCH: state_nxt = S_WAIT;
      S_WAIT:   if (done_edge || timeout_hit) state_nxt = S_REPORT;
      S_REPORT: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state        <= S_IDLE;
      rr_ptr       <= '0;
      job_id       <= '0;
      wr_base_addr <= '0;
      wr_burst_len <= '0;
      done_q       <= 1'b0;
      to_cnt       <= '0;
      err_q        <= 1'b0;
      tmo_q        <= 1'b0;
    end else begin
      state  <= state_nxt;
      // A level left high by the previous job must not look like a new edge.
      done_q <= (state == S_LAUNCH) ? 1'b1 : wr_txn_done;
      if (accept) begin
        wr_base_addr <= req_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
        wr_burst_len <= winner_len;
        job_id       <= winner;
        err_q        <= 1'b0;
        tmo_q        <= 1'b0;
      end
      if (state == S_WAIT) begin
        to_cnt <= to_cnt + CNT_W'(1);
        if (done_edge) begin
          err_q <= wr_error;
        end else if (timeout_hit) begin
          err_q <= 1'b1;
          tmo_q <= 1'b1;
        end
      end else begin
        to_cnt <= '0;
      end
      if (state == S_REPORT)
        rr_ptr <= (job_id == ID_W'(NUM_REQ - 1)) ? '0 : job_id + ID_W'(1);
    end
  end

  assign wr_init_txn = (state == S_LAUNCH);
  assign cpl_valid   = (state == S_REPORT);
  assign cpl_id      = job_id;
  assign cpl_error   = cpl_valid & err_q;
  assign cpl_timeout = cpl_valid & tmo_q;
  assign busy        = (state != S_IDLE);

`ifdef WRITER_JOB_SCHED_STATS_EN
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      stat_jobs <= '0;
      stat_errs <= '0;
    end else if (cpl_valid) begin
      if (stat_jobs != 16'hFFFF) stat_jobs <= stat_jobs + 16'd1;
      if (cpl_error && stat_errs != 16'hFFFF) stat_errs <= stat_errs + 16'd1;
    end
  end
`endif

endmodule
